// File: rtl/mdu_exec_pkg.sv
// mdu_exec_pkg: shared definitions for the E-stage multiply/divide unit.
// Holds the MDU opcode encodings (as `define macros for the E-stage decoder
// and as typed localparams for RTL), latency defaults and the IDLE/RUN
// state encoding.
// Optional feature macro: MDU_MADD_EN (decode MADD/MADDU/MSUB/MSUBU).

`ifndef MDU_EXEC_DEFS
`define MDU_EXEC_DEFS
`define MDU_OP_NONE       4'd0
`define MDU_OP_MULT       4'd1
`define MDU_OP_MULTU      4'd2
`define MDU_OP_DIV        4'd3
`define MDU_OP_DIVU       4'd4
`define MDU_OP_MFHI       4'd5
`define MDU_OP_MFLO       4'd6
`define MDU_OP_MTHI       4'd7
`define MDU_OP_MTLO       4'd8
`define MDU_OP_MADD       4'd9
`define MDU_OP_MADDU      4'd10
`define MDU_OP_MSUB       4'd11
`define MDU_OP_MSUBU      4'd12
`define MDU_MULT_LAT_DEF  5
`define MDU_DIV_LAT_DEF   10
`define MDU_STATE_IDLE    1'b0
`define MDU_STATE_RUN     1'b1
`endif

package mdu_exec_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 5;

    localparam logic [OP_W-1:0] OP_NONE  = `MDU_OP_NONE;
    localparam logic [OP_W-1:0] OP_MULT  = `MDU_OP_MULT;
    localparam logic [OP_W-1:0] OP_MULTU = `MDU_OP_MULTU;
    localparam logic [OP_W-1:0] OP_DIV   = `MDU_OP_DIV;
    localparam logic [OP_W-1:0] OP_DIVU  = `MDU_OP_DIVU;
    localparam logic [OP_W-1:0] OP_MFHI  = `MDU_OP_MFHI;
    localparam logic [OP_W-1:0] OP_MFLO  = `MDU_OP_MFLO;
    localparam logic [OP_W-1:0] OP_MTHI  = `MDU_OP_MTHI;
    localparam logic [OP_W-1:0] OP_MTLO  = `MDU_OP_MTLO;
    localparam logic [OP_W-1:0] OP_MADD  = `MDU_OP_MADD;
    localparam logic [OP_W-1:0] OP_MADDU = `MDU_OP_MADDU;
    localparam logic [OP_W-1:0] OP_MSUB  = `MDU_OP_MSUB;
    localparam logic [OP_W-1:0] OP_MSUBU = `MDU_OP_MSUBU;

    localparam int unsigned MULT_LAT_DEF = `MDU_MULT_LAT_DEF;
    localparam int unsigned DIV_LAT_DEF  = `MDU_DIV_LAT_DEF;

    typedef enum logic {
        IDLE = `MDU_STATE_IDLE,
        RUN  = `MDU_STATE_RUN
    } mdu_state_t;

endpackage

// File: rtl/mdu_exec.sv
// mdu_exec: E-stage multiply/divide unit with private HI/LO registers.
// Runs mult/multu/div/divu as fixed-latency multi-cycle operations and
// serves mfhi/mflo/mthi/mtlo. Requests an F/D stall while busy.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU accumulate).
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   start, op     E-stage MDU instruction valid / opcode
//   a, b          forwarded rs / rt operands
//   busy          multi-cycle operation in flight (registered)
//   md_stall      combinational stall request to the hazard unit
//   hi, lo        HI/LO registers
//   rd_out        combinational mfhi/mflo read data

module mdu_exec
    import mdu_exec_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              md_stall,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] rd_out
);

    mdu_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;

    // Input opcode classification
    logic op_mul;
    logic op_mac;
    logic op_div;
    logic op_multi;
    logic op_known;

    always_comb begin
        op_mul = (op == OP_MULT) || (op == OP_MULTU);
        op_div = (op == OP_DIV)  || (op == OP_DIVU);
`ifdef MDU_MADD_EN
        op_mac = (op == OP_MADD) || (op == OP_MADDU) ||
                 (op == OP_MSUB) || (op == OP_MSUBU);
`else
        op_mac = 1'b0;
`endif
        op_multi = op_mul || op_mac || op_div;
        // Undefined codes behave like NONE and never stall
        op_known = op_multi || (op == OP_MFHI) || (op == OP_MFLO) ||
                   (op == OP_MTHI) || (op == OP_MTLO);
        md_stall = start && op_known && (busy || op_multi);
        rd_out   = '0;
        if (op == OP_MFHI) begin
            rd_out = hi;
        end else if (op == OP_MFLO) begin
            rd_out = lo;
        end
    end

    // Result datapath computed from latched operands
    logic signed [63:0]  prod_s;
    logic [63:0]         prod_u;
    logic                div_ovf;
    logic [DATA_W-1:0]   quo_s;
    logic [DATA_W-1:0]   rem_s;
    logic [DATA_W-1:0]   quo_u;
    logic [DATA_W-1:0]   rem_u;
    logic [63:0]         result;
    logic                wr_ok;

    always_comb begin
        prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u = {32'b0, a_q} * {32'b0, b_q};
        // INT_MIN / -1 overflows; pin the architecturally defined result
        div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
        quo_s = '0;
        rem_s = '0;
        quo_u = '0;
        rem_u = '0;
        if (b_q != '0) begin
            quo_u = a_q / b_q;
            rem_u = a_q % b_q;
            if (div_ovf) begin
                quo_s = 32'h8000_0000;
            end else begin
                quo_s = 32'($signed(a_q) / $signed(b_q));
                rem_s = 32'($signed(a_q) % $signed(b_q));
            end
        end
        wr_ok = 1'b1;
        result = {hi, lo};
        case (op_q)
            OP_MULT:  result = 64'(prod_s);
            OP_MULTU: result = prod_u;
            OP_DIV: begin
                result = {rem_s, quo_s};
                wr_ok  = (b_q != '0);
            end
            OP_DIVU: begin
                result = {rem_u, quo_u};
                wr_ok  = (b_q != '0);
            end
`ifdef MDU_MADD_EN
            OP_MADD:  result = {hi, lo} + 64'(prod_s);
            OP_MADDU: result = {hi, lo} + prod_u;
            OP_MSUB:  result = {hi, lo} - 64'(prod_s);
            OP_MSUBU: result = {hi, lo} - prod_u;
`endif
            default: wr_ok = 1'b0;
        endcase
    end

    // Control FSM, latency counter and HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            op_q  <= OP_NONE;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && op_multi) begin
                        op_q  <= op;
                        a_q   <= a;
                        b_q   <= b;
                        cnt   <= op_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                        state <= RUN;
                        busy  <= 1'b1;
                    end else if (start && (op == OP_MTHI)) begin
                        hi <= a;
                    end else if (start && (op == OP_MTLO)) begin
                        lo <= a;
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        if (wr_ok) begin
                            hi <= result[63:32];
                            lo <= result[31:0];
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_exec.sv
// tb_mdu_exec: directed self-checking bench for mdu_exec (default latencies).

module tb_mdu_exec;

    localparam logic [3:0] NONE  = 4'd0;
    localparam logic [3:0] MULT  = 4'd1;
    localparam logic [3:0] MULTU = 4'd2;
    localparam logic [3:0] DIV   = 4'd3;
    localparam logic [3:0] DIVU  = 4'd4;
    localparam logic [3:0] MFHI  = 4'd5;
    localparam logic [3:0] MFLO  = 4'd6;
    localparam logic [3:0] MTHI  = 4'd7;
    localparam logic [3:0] MTLO  = 4'd8;
    localparam logic [3:0] MADDU = 4'd10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_out;

    int checks = 0;
    int errors = 0;

    mdu_exec dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo),
        .rd_out   (rd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one MDU instruction for one edge, then return inputs to idle
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
        op    = NONE;
        a     = '0;
        b     = '0;
    endtask

    // Count cycles busy stays high (bounded)
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
    endtask

    int n;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = NONE;
        a     = '0;
        b     = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall", 32'(md_stall), 32'd0);
        chk("rst_rd", rd_out, 32'd0);

        // MULT -2 * 3
        start = 1'b1; op = MULT; a = 32'hFFFF_FFFE; b = 32'd3;
        #1;
        chk("mult_launch_stall", 32'(md_stall), 32'd1);
        tick();
        start = 1'b0; op = NONE;
        count_busy(n);
        chk("mult_busy_cycles", 32'(n), 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        // MULTU max*max with a second start held during busy
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        start = 1'b1; op = MULT; a = 32'd0; b = 32'd0;
        #1;
        chk("busy_second_stall", 32'(md_stall), 32'd1);
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        start = 1'b0; op = NONE;
        chk("multu_busy_cycles", 32'(n), 32'd5);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);
        tick();
        chk("multu_hold_busy", 32'(busy), 32'd0);
        chk("multu_hold_hi", hi, 32'hFFFF_FFFE);

        // DIV -7 / 2
        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        count_busy(n);
        chk("div_busy_cycles", 32'(n), 32'd10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        // DIVU by zero keeps HI/LO but still takes full latency
        issue(DIVU, 32'd7, 32'd0);
        count_busy(n);
        chk("divz_busy_cycles", 32'(n), 32'd10);
        chk("divz_lo", lo, 32'hFFFF_FFFD);
        chk("divz_hi", hi, 32'hFFFF_FFFF);

        // Signed overflow division
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(n);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'h0000_0000);

        // DIVU 100 / 7
        issue(DIVU, 32'd100, 32'd7);
        count_busy(n);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        // MTHI then MFHI
        start = 1'b1; op = MTHI; a = 32'h1234_5678;
        #1;
        chk("mthi_stall", 32'(md_stall), 32'd0);
        tick();
        chk("mthi_busy", 32'(busy), 32'd0);
        op = MFHI; a = '0;
        #1;
        chk("mfhi_rd", rd_out, 32'h1234_5678);
        chk("mfhi_stall", 32'(md_stall), 32'd0);
        tick();
        op = MTLO; a = 32'hCAFE_F00D;
        tick();
        op = MFLO; a = '0;
        #1;
        chk("mflo_rd", rd_out, 32'hCAFE_F00D);
        tick();
        start = 1'b0; op = NONE;

        // MFLO while busy must stall; back-to-back op accepted when busy falls
        issue(MULT, 32'h0001_0000, 32'h0001_0000);
        start = 1'b1; op = MFLO;
        #1;
        chk("mflo_busy_stall", 32'(md_stall), 32'd1);
        start = 1'b0; op = NONE;
        count_busy(n);
        chk("mult2_hi", hi, 32'd1);
        chk("mult2_lo", lo, 32'd0);
        issue(MULTU, 32'd3, 32'd4);
        chk("b2b_busy", 32'(busy), 32'd1);
        count_busy(n);
        chk("b2b_cycles", 32'(n), 32'd5);
        chk("b2b_lo", lo, 32'd12);
        chk("b2b_hi", hi, 32'd0);

        // Reset in the middle of a DIV
        issue(DIV, 32'd100, 32'd3);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstrun_busy", 32'(busy), 32'd0);
        chk("rstrun_hi", hi, 32'd0);
        chk("rstrun_lo", lo, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        chk("rstrun_late_hi", hi, 32'd0);
        chk("rstrun_late_lo", lo, 32'd0);

        // MADDU: accumulate when enabled, no effect otherwise
        issue(MTHI, 32'd0, 32'd0);
        issue(MTLO, 32'hFFFF_FFFF, 32'd0);
        start = 1'b1; op = MADDU; a = 32'd1; b = 32'd1;
        #1;
`ifdef MDU_MADD_EN
        chk("maddu_stall", 32'(md_stall), 32'd1);
        tick();
        start = 1'b0; op = NONE; a = '0; b = '0;
        count_busy(n);
        chk("maddu_cycles", 32'(n), 32'd5);
        chk("maddu_hi", hi, 32'd1);
        chk("maddu_lo", lo, 32'd0);
`else
        chk("maddu_stall", 32'(md_stall), 32'd0);
        tick();
        start = 1'b0; op = NONE; a = '0; b = '0;
        chk("maddu_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 6; i++) tick();
        chk("maddu_hi", hi, 32'd0);
        chk("maddu_lo", lo, 32'hFFFF_FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
